adj_time_keeper: RTL and testbench

Minute/second timekeeper for the stopwatch. It is the consumer of the adjustment pulses `sig_minute_adj` and `sig_second_adj`. It also runs the normal one-second count from a clock prescaler. Its BCD digit outputs feed the seven-segment display driver.

---
 rtl/adj_time_keeper.sv | 142 ++++++++++++++
 tb/tb_adj_time_keeper.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adj_time_keeper.sv
`default_nettype none
// ============================================================================
// Module   : adj_time_keeper
// Brief    : MM:SS BCD stopwatch timekeeper. Runs from a one-second
//            prescaler, with pause and per-field increment adjust modes.
// Revision : 1.0 - initial release
// ============================================================================
module adj_time_keeper #(
    parameter int DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] adj_state,
    input  logic       pause,
    input  logic       sig_minute_adj,
    input  logic       sig_second_adj,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] adj_ack,
    output logic       blink
);

    localparam int                c_PS_W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(DIV - 1);
    localparam logic [c_PS_W-1:0] c_PS_HALF = c_PS_W'(DIV / 2 - 1);

    logic [c_PS_W-1:0] r_ps;
    logic              r_running;
    logic              r_was_adj;
    logic              r_prev_m;
    logic              r_prev_s;
    logic [2:0]        r_min_tens;
    logic [3:0]        r_min_ones;
    logic [2:0]        r_sec_tens;
    logic [3:0]        r_sec_ones;
    logic [1:0]        r_ack;
    logic              r_blink;

    logic       w_min_mode;
    logic       w_sec_mode;
    logic       w_run;
    logic       w_enter_run;
    logic       w_tick;
    logic       w_req_m;
    logic       w_req_s;
    logic       w_sec_carry;
    logic [6:0] w_sec_inc;
    logic [6:0] w_min_inc;
    logic [6:0] w_sec_nx;
    logic [6:0] w_min_nx;
    logic [1:0] w_ack_nx;

    // Two-digit BCD increment, 59 wraps to 00; result is {tens, ones}.
    function automatic logic [6:0] f_bcd_inc(input logic [2:0] tens, input logic [3:0] ones);
        if (ones != 4'd9)
            return {tens, ones + 4'd1};
        else if (tens != 3'd5)
            return {tens + 3'd1, 4'd0};
        else
            return 7'd0;
    endfunction

    assign w_min_mode  = (adj_state == 2'b01);
    assign w_sec_mode  = (adj_state == 2'b10);
    assign w_run       = !(w_min_mode || w_sec_mode);
    assign w_enter_run = w_run && r_was_adj;
    assign w_tick      = (r_ps == c_PS_LAST);
    assign w_req_m     = sig_minute_adj && !r_prev_m;
    assign w_req_s     = sig_second_adj && !r_prev_s;
    assign w_sec_carry = (r_sec_tens == 3'd5) && (r_sec_ones == 4'd9);
    assign w_sec_inc   = f_bcd_inc(r_sec_tens, r_sec_ones);
    assign w_min_inc   = f_bcd_inc(r_min_tens, r_min_ones);

    always_comb begin
        w_sec_nx = {r_sec_tens, r_sec_ones};
        w_min_nx = {r_min_tens, r_min_ones};
        w_ack_nx = 2'b00;
        if (w_run) begin
            // The edge that leaves adjust restarts the second, so no tick there.
            if (r_running && w_tick && !w_enter_run) begin
                w_sec_nx = w_sec_inc;
                if (w_sec_carry)
                    w_min_nx = w_min_inc;
            end
        end else if (w_min_mode) begin
            if (w_req_m) begin
                w_min_nx = w_min_inc;
                w_ack_nx = 2'b10;
            end
        end else if (w_req_s) begin
            w_sec_nx = w_sec_inc;
            w_ack_nx = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ps       <= '0;
            r_running  <= 1'b1;
            r_was_adj  <= 1'b0;
            r_prev_m   <= 1'b1;
            r_prev_s   <= 1'b1;
            r_min_tens <= 3'd0;
            r_min_ones <= 4'd0;
            r_sec_tens <= 3'd0;
            r_sec_ones <= 4'd0;
            r_ack      <= 2'b00;
            r_blink    <= 1'b0;
        end else begin
            r_prev_m  <= sig_minute_adj;
            r_prev_s  <= sig_second_adj;
            r_was_adj <= !w_run;
            if (pause)
                r_running <= !r_running;

            if (w_enter_run)
                r_ps <= '0;
            else if (!w_run || r_running)
                r_ps <= w_tick ? '0 : r_ps + 1'b1;

            if (w_run)
                r_blink <= 1'b0;
            else if ((r_ps == c_PS_HALF) || w_tick)
                r_blink <= !r_blink;

            {r_min_tens, r_min_ones} <= w_min_nx;
            {r_sec_tens, r_sec_ones} <= w_sec_nx;
            r_ack <= w_ack_nx;
        end
    end

    assign min_tens = r_min_tens;
    assign min_ones = r_min_ones;
    assign sec_tens = r_sec_tens;
    assign sec_ones = r_sec_ones;
    assign adj_ack  = r_ack;
    assign blink    = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_adj_time_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_adj_time_keeper
// Brief    : Self-checking bench for adj_time_keeper (DIV=4 and DIV=8 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adj_time_keeper;

    typedef struct {
        logic [1:0] ack;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] adj_state = 2'b00;
    logic [1:0] adj_state8 = 2'b00;
    logic       pause = 1'b0;
    logic       sig_m = 1'b0;
    logic       sig_s = 1'b0;

    logic [2:0] min_tens, sec_tens, min_tens8, sec_tens8;
    logic [3:0] min_ones, sec_ones, min_ones8, sec_ones8;
    logic [1:0] adj_ack, adj_ack8;
    logic       blink, blink8;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_ack_m = 0;
    int   n_ack_s = 0;
    int   exp_min = 0;
    int   exp_sec = 0;
    int   base_m, base_s;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    adj_time_keeper #(.DIV(4)) dut (
        .clk(clk), .reset(reset), .adj_state(adj_state), .pause(pause),
        .sig_minute_adj(sig_m), .sig_second_adj(sig_s),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .adj_ack(adj_ack), .blink(blink)
    );

    adj_time_keeper #(.DIV(8)) dut8 (
        .clk(clk), .reset(reset), .adj_state(adj_state8), .pause(1'b0),
        .sig_minute_adj(1'b0), .sig_second_adj(1'b0),
        .min_tens(min_tens8), .min_ones(min_ones8), .sec_tens(sec_tens8), .sec_ones(sec_ones8),
        .adj_ack(adj_ack8), .blink(blink8)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic int t_of(input logic [2:0] mt, input logic [3:0] mo,
                                input logic [2:0] st, input logic [3:0] so);
        return (int'(mt) * 10 + int'(mo)) * 100 + int'(st) * 10 + int'(so);
    endfunction

    function automatic int now_t();
        return t_of(min_tens, min_ones, sec_tens, sec_ones);
    endfunction

    function automatic int now_t8();
        return t_of(min_tens8, min_ones8, sec_tens8, sec_ones8);
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one request pulse followed by one low cycle; queue the expected ack.
    task automatic send(input bit m, input bit s, input int width,
                        input logic [1:0] ack, input int expv);
        exp_t e;
        sig_m = m;
        sig_s = s;
        if (ack != 2'b00) begin
            e.ack = ack;
            e.t   = expv;
            sb_q.push_back(e);
        end
        cyc(width);
        sig_m = 1'b0;
        sig_s = 1'b0;
        cyc(1);
    endtask

    always @(negedge clk) begin
        if (adj_ack != 2'b00) begin
            exp_t e;
            if (adj_ack[1]) n_ack_m++;
            if (adj_ack[0]) n_ack_s++;
            if (sb_q.size() == 0) begin
                chk("ack_unexpected", int'(adj_ack), 0);
            end else begin
                e = sb_q.pop_front();
                chk("ack_bits", int'(adj_ack), int'(e.ack));
                chk("ack_time", now_t(), e.t);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cyc(3);
        chk("rst_time", now_t(), 0);
        chk("rst_ack", int'(adj_ack), 0);
        chk("rst_blink", int'(blink), 0);
        chk("rst_time8", now_t8(), 0);

        // Free run: one step every 4 cycles, 01:00 after 240 cycles.
        reset = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            cyc(3);
            chk("run_hold", now_t(), ((k - 1) / 60) * 100 + (k - 1) % 60);
            cyc(1);
            chk("run_step", now_t(), (k / 60) * 100 + k % 60);
        end
        chk("run_60s", now_t(), 100);
        chk("run_blink", int'(blink), 0);

        // Pause at 01:03 with the prescaler part-way, then resume.
        cyc(13);
        chk("pre_pause", now_t(), 103);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        cyc(40);
        chk("paused_hold", now_t(), 103);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        cyc(1);
        chk("resume_wait", now_t(), 103);
        cyc(1);
        chk("resume_step", now_t(), 104);

        // Minute adjust: 61 pulses from minute 01 wraps through 59 to 02.
        exp_min = 1;
        exp_sec = 4;
        adj_state = 2'b01;
        cyc(1);
        base_m = n_ack_m;
        base_s = n_ack_s;
        for (int i = 0; i < 61; i++) begin
            exp_min = (exp_min + 1) % 60;
            send(1'b1, 1'b0, 4, 2'b10, exp_min * 100 + exp_sec);
        end
        chk("madj_time", now_t(), 204);
        chk("madj_acks", n_ack_m - base_m, 61);
        chk("madj_no_sec_ack", n_ack_s - base_s, 0);
        for (int i = 0; i < 10; i++) begin
            exp_min = exp_min + 1;
            send(1'b1, 1'b0, 2, 2'b10, exp_min * 100 + exp_sec);
        end

        // Second adjust to 12:59, then a wide pulse with a concurrent minute request.
        adj_state = 2'b10;
        cyc(1);
        for (int i = 0; i < 55; i++) begin
            exp_sec = exp_sec + 1;
            send(1'b0, 1'b1, 1, 2'b01, exp_min * 100 + exp_sec);
        end
        chk("sadj_1259", now_t(), 1259);
        base_m = n_ack_m;
        base_s = n_ack_s;
        exp_sec = 0;
        send(1'b1, 1'b1, 8, 2'b01, 1200);
        chk("sadj_wrap", now_t(), 1200);
        chk("sadj_one_ack", n_ack_s - base_s, 1);
        chk("sadj_no_min_ack", n_ack_m - base_m, 0);

        // Preset 59:59 and let one tick wrap it.
        for (int i = 0; i < 59; i++) begin
            exp_sec = exp_sec + 1;
            send(1'b0, 1'b1, 1, 2'b01, exp_min * 100 + exp_sec);
        end
        adj_state = 2'b01;
        cyc(1);
        for (int i = 0; i < 47; i++) begin
            exp_min = exp_min + 1;
            send(1'b1, 1'b0, 1, 2'b10, exp_min * 100 + exp_sec);
        end
        chk("preset_5959", now_t(), 5959);
        adj_state = 2'b00;
        cyc(1);
        chk("exit_blink", int'(blink), 0);
        cyc(3);
        chk("exit_hold", now_t(), 5959);
        cyc(1);
        chk("wrap_0000", now_t(), 0);

        // Reset in the middle of a minute pulse.
        adj_state = 2'b01;
        cyc(2);
        send(1'b1, 1'b0, 0, 2'b10, 100);
        sig_m = 1'b1;
        cyc(2);
        reset = 1'b0;
        adj_state8 = 2'b01;
        cyc(2);
        chk("rstmid_time", now_t(), 0);
        chk("rstmid_ack", int'(adj_ack), 0);
        reset = 1'b1;

        // Blink on the DIV=8 instance while the request is still held high.
        for (int k = 0; k <= 20; k++) begin
            cyc(1);
            if (k == 2) sig_m = 1'b0;
            chk("blink8", int'(blink8), ((k + 1) / 4) % 2);
        end
        chk("rstmid_no_inc", now_t(), 0);
        chk("ack8_none", int'(adj_ack8), 0);
        adj_state8 = 2'b00;
        cyc(1);
        chk("exit8_blink", int'(blink8), 0);
        chk("exit8_time", now_t8(), 0);
        cyc(7);
        chk("exit8_hold", now_t8(), 0);
        cyc(1);
        chk("exit8_tick", now_t8(), 1);

        send(1'b1, 1'b0, 4, 2'b10, 100);
        chk("fresh_pulse", now_t(), 100);
        cyc(2);
        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
